// File: rtl/deco_block_decoder_if.sv
// Word-in / decision-out bundle for the block decoder.
// Master drives words and the strobe; slave returns the registered decision.
interface deco_block_decoder_if #(
    parameter int WORD_W = 21,
    parameter int MSG_W  = 5
);
    logic              start_i;
    logic [WORD_W-1:0] data_i;
    logic [MSG_W-1:0]  data_o;
    logic              done_o;

    modport master (
        output start_i,
        output data_i,
        input  data_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  data_i,
        output data_o,
        output done_o
    );
endinterface

// File: rtl/deco_block_decoder.sv
// Soft-decision ML decoder of a 5-bit message over 28 symbols; 4-word load, 33-cycle search.
// No backpressure: start_i/data_i are ignored while searching or reporting.
module deco_block_decoder #(
    parameter int WORD_W    = 21,
    parameter int NUM_WORDS = 4,
    parameter int SYM_W     = 3,
    parameter int NUM_SYM   = 28,
    parameter int MSG_W     = 5
) (
    input  logic                 clk_p_i,
    input  logic                 reset_n_i,
    deco_block_decoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;

    localparam int BLK_W   = WORD_W * NUM_WORDS;
    localparam int SCORE_W = 8;
    localparam int CAND_W  = MSG_W + 1;
    localparam logic [1:0] LAST_WORD = 2'(NUM_WORDS - 1);

    state_t                    state;
    logic [BLK_W-1:0]          blk;
    logic [1:0]                word_cnt;
    logic [CAND_W-1:0]         cand;
    logic signed [SCORE_W-1:0] best_score;
    logic [MSG_W-1:0]          best_m;
    logic [MSG_W-1:0]          data_q;
    logic                      done_q;

    logic signed [SCORE_W-1:0] score;
    logic signed [SCORE_W-1:0] sym_ext;
    logic [MSG_W-1:0]          kp1;
    logic                      cbit;

    // Correlation of the current candidate's codeword against the soft symbols.
    always_comb begin
        score   = '0;
        sym_ext = '0;
        kp1     = '0;
        cbit    = 1'b0;
        for (int k = 0; k < NUM_SYM; k++) begin
            sym_ext = {{(SCORE_W-SYM_W){blk[k*SYM_W+SYM_W-1]}}, blk[k*SYM_W +: SYM_W]};
            kp1     = MSG_W'(k + 1);
            cbit    = ^(cand[MSG_W-1:0] & kp1);
            score   = cbit ? (score - sym_ext) : (score + sym_ext);
        end
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= IDLE;
            blk        <= '0;
            word_cnt   <= '0;
            cand       <= '0;
            best_score <= '0;
            best_m     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        blk[WORD_W-1:0] <= bus.data_i;
                        word_cnt        <= 2'd1;
                        state           <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.start_i) begin
                        blk[word_cnt*WORD_W +: WORD_W] <= bus.data_i;
                        word_cnt <= word_cnt + 2'd1;
                        if (word_cnt == LAST_WORD) begin
                            cand  <= '0;
                            state <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    // cand's top bit marks that all 32 candidates have been scored.
                    if (cand[MSG_W]) begin
                        data_q <= best_m;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        if ((cand == '0) || (score > best_score)) begin
                            best_score <= score;
                            best_m     <= cand[MSG_W-1:0];
                        end
                        cand <= cand + CAND_W'(1);
                    end
                end
                DONE: begin
                    done_q   <= 1'b0;
                    word_cnt <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_o = data_q;
    assign bus.done_o = done_q;
endmodule

// File: tb/tb_deco_block_decoder.sv
// Directed and randomized checks of the block decoder against hand values and a reference argmax.
module tb_deco_block_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    deco_block_decoder_if bus ();

    deco_block_decoder dut (
        .clk_p_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [83:0] make_cw(input logic [4:0] m);
        logic [83:0] b;
        logic [4:0]  kk;
        b = '0;
        for (int k = 0; k < 28; k++) begin
            kk = 5'(k + 1);
            b[3*k +: 3] = (^(m & kk)) ? 3'b101 : 3'b011;
        end
        return b;
    endfunction

    function automatic logic [4:0] ref_decode(input logic [83:0] b);
        int best, s, l;
        logic [4:0] bm, mm, kk;
        logic [2:0] t;
        best = -1000;
        bm   = '0;
        for (int m = 0; m < 32; m++) begin
            s  = 0;
            mm = 5'(m);
            for (int k = 0; k < 28; k++) begin
                t  = b[3*k +: 3];
                l  = int'(t);
                if (l >= 4) l = l - 8;
                kk = 5'(k + 1);
                s  = (^(mm & kk)) ? s - l : s + l;
            end
            if (s > best) begin
                best = s;
                bm   = mm;
            end
        end
        return bm;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the DONE->IDLE edge.
    task automatic run_block(input logic [83:0] blk, input bit hold, input logic [4:0] exp, input string tag);
        int done_at;
        logic [4:0] held;
        done_at = 0;
        for (int j = 0; j < 4; j++) begin
            bus.start_i = 1'b1;
            bus.data_i  = blk[j*21 +: 21];
            @(negedge clk);
        end
        if (!hold) bus.start_i = 1'b0;
        bus.data_i = 21'($urandom);
        for (int n = 1; n <= 40 && done_at == 0; n++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) done_at = n;
            bus.data_i = 21'($urandom);
        end
        vec_cnt++;
        if (done_at !== 33) begin
            err_cnt++;
            $display("FAIL %s done_latency: got %0d edges, want 33", tag, done_at);
        end
        vec_cnt++;
        if (bus.data_o !== exp) begin
            err_cnt++;
            $display("FAIL %s data_o: got %b, want %b", tag, bus.data_o, exp);
        end
        held = bus.data_o;
        bus.start_i = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (bus.done_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s done_width: done_o got %b one cycle later, want 0", tag, bus.done_o);
        end
        vec_cnt++;
        if (bus.data_o !== held) begin
            err_cnt++;
            $display("FAIL %s data_hold: got %b, want %b", tag, bus.data_o, held);
        end
    endtask

    task automatic test_reset;
        bus.start_i = 1'b0;
        bus.data_i  = '0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (bus.data_o !== 5'd0) begin
            err_cnt++;
            $display("FAIL reset data_o: got %b, want 00000", bus.data_o);
        end
        vec_cnt++;
        if (bus.done_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset done_o: got %b, want 0", bus.done_o);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (bus.done_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL idle done_o: got %b, want 0", bus.done_o);
        end
    endtask

    task automatic test_all_plus3;
        run_block({28{3'b011}}, 1'b0, 5'd0, "plus3");
    endtask

    task automatic test_m1;
        run_block(make_cw(5'd1), 1'b0, 5'b00001, "m1");
    endtask

    task automatic test_zeros;
        run_block(84'd0, 1'b0, 5'd0, "zeros");
    endtask

    task automatic test_m22_hold;
        run_block(make_cw(5'd22), 1'b1, 5'b10110, "m22_hold");
    endtask

    task automatic test_abort;
        logic [83:0] b;
        b = make_cw(5'd22);
        for (int j = 0; j < 3; j++) begin
            bus.start_i = 1'b1;
            bus.data_i  = b[j*21 +: 21];
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (bus.data_o !== 5'd0) begin
            err_cnt++;
            $display("FAIL abort reset data_o: got %b, want 00000", bus.data_o);
        end
        vec_cnt++;
        if (bus.done_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort reset done_o: got %b, want 0", bus.done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_block(make_cw(5'd1), 1'b0, 5'b00001, "abort_m1");
    endtask

    task automatic test_back_to_back_random;
        logic [83:0] b;
        for (int i = 0; i < 672; i++) begin
            b = {20'($urandom), $urandom, $urandom};
            run_block(b, 1'b1, ref_decode(b), "rand");
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.data_i  = '0;
        test_reset();
        test_all_plus3();
        test_m1();
        test_zeros();
        test_m22_hold();
        test_abort();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
